// File: rtl/pwm_duty_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_ramp_ctrl
// Brief   : Ramps the PWM duty toward a host/button target one step per
//           period boundary, with a minimum inter-step delay.
// Option  : PWM_RAMP_RETARGET_EN allows host retargeting during a ramp.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W      = 4,
  parameter int DUTY_MAX    = 10,
  parameter int INIT_DUTY   = 5,
  parameter int STEP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req_valid,
  input  logic [DUTY_W-1:0] host_req_duty,
  output logic              host_req_ready,
  input  logic              btn_inc_pulse,
  input  logic              btn_dec_pulse,
  input  logic              period_start,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              ack,
  output logic              err_range
);

  localparam logic [DUTY_W-1:0] C_DUTY_MAX  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] C_INIT_DUTY = DUTY_W'(INIT_DUTY);
  localparam logic [DUTY_W-1:0] C_ONE       = DUTY_W'(1);
  localparam logic [15:0]       C_RELOAD    = 16'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_DELAY  = 2'd1,
    S_WAIT_PERIOD = 2'd2
  } state_t;

  state_t            state_q,  state_d;
  logic [DUTY_W-1:0] duty_q,   duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [15:0]       cnt_q,    cnt_d;
  logic              busy_q,   busy_d;
  logic              ack_q,    ack_d;
  logic              err_q,    err_d;

  logic              host_acc;
  logic              host_over;
  logic [DUTY_W-1:0] host_clamped;
  logic              inc_ok;
  logic              dec_ok;
  logic [DUTY_W-1:0] eff_target;
  logic [DUTY_W-1:0] duty_step;

  assign host_over    = (host_req_duty > C_DUTY_MAX);
  assign host_clamped = host_over ? C_DUTY_MAX : host_req_duty;

`ifdef PWM_RAMP_RETARGET_EN
  assign host_req_ready = (state_q == S_IDLE) || (state_q == S_WAIT_DELAY) ||
                          (state_q == S_WAIT_PERIOD);
`else
  assign host_req_ready = (state_q == S_IDLE);
`endif

  assign host_acc = host_req_valid & host_req_ready;
  // Simultaneous inc+dec cancels out; requests at a limit are dropped.
  assign inc_ok   = btn_inc_pulse & ~btn_dec_pulse & (duty_q < C_DUTY_MAX);
  assign dec_ok   = btn_dec_pulse & ~btn_inc_pulse & (duty_q != '0);

  // A retarget accepted during a ramp takes effect in the same cycle.
  assign eff_target = host_acc ? host_clamped : target_q;
  assign duty_step  = (eff_target > duty_q) ? (duty_q + C_ONE) : (duty_q - C_ONE);

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    err_d    = host_acc & host_over;
    if (host_acc) begin
      target_d = host_clamped;
    end
    case (state_q)
      S_IDLE: begin
        if (host_acc) begin
          if (host_clamped == duty_q) begin
            ack_d = 1'b1;
          end else begin
            state_d = S_WAIT_DELAY;
            cnt_d   = C_RELOAD;
            busy_d  = 1'b1;
          end
        end else if (inc_ok) begin
          target_d = duty_q + C_ONE;
          state_d  = S_WAIT_DELAY;
          cnt_d    = C_RELOAD;
          busy_d   = 1'b1;
        end else if (dec_ok) begin
          target_d = duty_q - C_ONE;
          state_d  = S_WAIT_DELAY;
          cnt_d    = C_RELOAD;
          busy_d   = 1'b1;
        end
      end
      S_WAIT_DELAY: begin
        if (eff_target == duty_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
        end else if (cnt_q == 16'd0) begin
          state_d = S_WAIT_PERIOD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_WAIT_PERIOD: begin
        if (eff_target == duty_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
        end else if (period_start) begin
          // Step only on a period boundary so no pulse is ever truncated.
          duty_d = duty_step;
          if (duty_step == eff_target) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ack_d   = 1'b1;
          end else begin
            state_d = S_WAIT_DELAY;
            cnt_d   = C_RELOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      duty_q   <= C_INIT_DUTY;
      target_q <= C_INIT_DUTY;
      cnt_q    <= 16'd0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign duty_out  = duty_q;
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign err_range = err_q;

endmodule
`default_nettype wire

// File: doc/pwm_duty_ramp_ctrl.md
# pwm_duty_ramp_ctrl

Duty-cycle controller for the 10-step PWM generator. It accepts target duty requests from a host port and from debounced inc/dec button pulses, with fixed priority: host first. It ramps its duty output toward the target one step at a time, with a minimum inter-step delay, and changes the duty only at PWM period boundaries so the output never produces a truncated pulse. It sits between the user/host logic and the PWM counter/comparator datapath and owns that datapath's duty register.

## Interface
- DUTY_W, 4, width of duty values.
- DUTY_MAX, 10, highest legal duty (steps of 10%).
- INIT_DUTY, 5, duty_out value after reset.
- STEP_CYCLES, 16, minimum clk cycles between consecutive steps; legal range 1..65535; the counter is 16 bits.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- host_req_valid  in  1  host target request.
- host_req_duty  in  DUTY_W  requested target duty.
- host_req_ready  out  1  request accepted when valid&ready at a rising edge.
- btn_inc_pulse  in  1  one-cycle request for duty+1.
- btn_dec_pulse  in  1  one-cycle request for duty-1.
- period_start  in  1  one-cycle pulse when the PWM counter wraps to 0.
- duty_out  out  DUTY_W  duty value driven into the PWM comparator.
- busy  out  1  ramp in progress.
- ack  out  1  one-cycle pulse: target reached.
- err_range  out  1  one-cycle pulse: host duty > DUTY_MAX (clamped).

## Operation
- States: IDLE, WAIT_DELAY, WAIT_PERIOD. Reset: IDLE, duty_out=INIT_DUTY, target=INIT_DUTY, busy=0, ack=0, err_range=0, delay counter=0.
- host_req_ready = (state==IDLE), combinational; it is 1 immediately after reset.
- IDLE, arbitration in priority order:
  - Host accept: target = min(host_req_duty, DUTY_MAX). err_range pulses the next cycle if clamped.
  - Otherwise, btn_inc_pulse alone with duty_out<DUTY_MAX: target = duty_out+1.
  - Otherwise, btn_dec_pulse alone with duty_out>0: target = duty_out-1.
  - inc and dec asserted together: ignored. A button request at a limit: ignored, no ack.
  - A button pulse in the same cycle as a host accept is dropped.
  - After accept with target==duty_out: ack pulses the next cycle and the state stays IDLE.
  - After accept with target!=duty_out: go to WAIT_DELAY with counter=STEP_CYCLES-1 and busy=1.
- WAIT_DELAY: the counter decrements each cycle. In the cycle where it is 0, go to WAIT_PERIOD. The state lasts exactly STEP_CYCLES cycles.
- WAIT_PERIOD: on the first edge sampling period_start=1, duty_out moves ±1 toward target.
  - If the new value equals target: go to IDLE, busy=0, and ack=1 for one cycle, all coincident with the new duty_out.
  - Otherwise: go back to WAIT_DELAY with the counter reloaded.
- period_start pulses arriving in WAIT_DELAY are ignored.
- Button pulses while not in IDLE are dropped, not queued.
- Arithmetic is unsigned DUTY_W bits. duty_out is always within 0..DUTY_MAX, with no wrap.
- Reset asserted mid-ramp aborts immediately to the reset values, with no ack.

## Timing
- Host accept at edge T: busy=1 from T+1. The earliest first step is at edge T+STEP_CYCLES+1, if period_start is high in that cycle.
- Every step is separated by at least STEP_CYCLES+1 cycles. No more than one step occurs per PWM period.
- A ramp of N steps produces exactly N duty_out changes and exactly one ack.
- Immediate match: ack at T+1, busy stays 0.
- err_range and ack are registered single-cycle pulses. No combinational path runs from inputs to duty_out.

## Configuration
- PWM_RAMP_RETARGET_EN defined:
  - host_req_ready is also 1 in WAIT_DELAY and WAIT_PERIOD.
  - An accept there replaces target (clamped, err_range as usual) without an ack for the old target.
  - The state and counter are unchanged.
  - If the new target equals the current duty_out, the block goes to IDLE with an ack the next cycle.
- Undefined: host_req_ready=0 outside IDLE, and requests wait.

## Test plan
- Reset, STEP_CYCLES=4, period_start every 10 cycles, host request 8:
  - duty_out 5→6→7→8, one step per period, each ≥5 cycles apart.
  - A single ack coincides with the 8; busy is high throughout.
- Host request 15 in IDLE -> err_range pulse, ramp to 10, ack; no step occurs beyond 10.
- Boundary buttons:
  - At duty 0, btn_dec -> no change, no ack.
  - btn_inc and btn_dec in the same cycle at duty 5 -> ignored.
  - btn_inc alone -> 6 with ack.
- host_req_valid (duty 2) and btn_inc in the same cycle at duty 5 -> host wins; ramp to 2, 3 steps.
- Reset asserted in WAIT_PERIOD during a 5→9 ramp -> duty_out=5, busy=0 immediately; no ack.
- With PWM_RAMP_RETARGET_EN:
  - Request 9, then request 6 while at duty 7 -> ramp reverses to 6, one ack only.
  - Without the macro, host_req_ready stays 0 until the first ack.
